// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares the single-port PUnC memory between instruction
// fetch, data access and the debug/loader port. One registered access at a
// time; reads are sequenced through a fixed latency and returned on rdata
// with a per-requester valid pulse. Every output is a flop.
module punc_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // One-hot requester ids, bit order {dbg, data, fetch}
  localparam logic [2:0] ID_F   = 3'b001;
  localparam logic [2:0] ID_D   = 3'b010;
  localparam logic [2:0] ID_DBG = 3'b100;

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [1:0]    LAT_INIT   = 2'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [2:0]        id_q, id_d;
  logic [1:0]        lat_q, lat_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  // Next-state: arbitration in IDLE, issue, latency count, response.
  // mem_addr/mem_wdata double as the latched request fields and hold
  // across the access; mem_we_q carries the latched direction into ISSUE.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    id_d        = id_q;
    lat_d       = lat_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (!f_req) starve_d = '0;
        if (dbg_req) begin
          id_d        = ID_DBG;
          mem_we_d    = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
        end else if (d_req && !(f_req && starve_q == STARVE_LIM)) begin
          id_d        = ID_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (f_req) starve_d = starve_q + SW'(1);
        end else if (f_req) begin
          id_d       = ID_F;
          mem_addr_d = f_addr;
          starve_d   = '0;
        end
        if (dbg_req || d_req || f_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          gnt_d    = id_d;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d  = RESP;
          rdata_d  = mem_rdata;
          rvalid_d = id_q;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      id_q        <= '0;
      lat_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      id_q        <= id_d;
      lat_q       <= lat_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign f_gnt      = gnt_q[0];
  assign d_gnt      = gnt_q[1];
  assign dbg_gnt    = gnt_q[2];
  assign f_rvalid   = rvalid_q[0];
  assign d_rvalid   = rvalid_q[1];
  assign dbg_rvalid = rvalid_q[2];
  assign rdata      = rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed bench for punc_mem_arbiter: one RD_LAT=1 instance backed by a
// small lookup memory, one RD_LAT=3 instance with bench-driven mem_rdata.
module tb_punc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_rdata = '0;

  logic        f_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0, dbg_req3 = 1'b0, dbg_we3 = 1'b0;
  logic [15:0] f_addr3 = '0, d_addr3 = '0, d_wdata3 = '0, dbg_addr3 = '0, dbg_wdata3 = '0;
  logic        f_gnt3, f_rvalid3, d_gnt3, d_rvalid3, dbg_gnt3, dbg_rvalid3;
  logic [15:0] rdata3, mem_addr3, mem_wdata3;
  logic        mem_en3, mem_we3, busy3;
  logic [15:0] mem_rdata3 = '0;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
    .dbg_req(dbg_req3), .dbg_we(dbg_we3), .dbg_addr(dbg_addr3), .dbg_wdata(dbg_wdata3),
    .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3),
    .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    case (a)
      16'h3000: return 16'h1234;
      16'h0200: return 16'h5A5A;
      16'h0400: return 16'h0F0F;
      default:  return 16'hDEAD;
    endcase
  endfunction

  // One-cycle read latency memory for the RD_LAT=1 instance
  always @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= mem_lookup(mem_addr);

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({f_gnt, d_gnt, dbg_gnt, f_rvalid, d_rvalid, dbg_rvalid, mem_en, mem_we, busy} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {f_gnt, d_gnt, dbg_gnt, f_rvalid, d_rvalid, dbg_rvalid, mem_en, mem_we, busy});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, rdata} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Fetch read of 0x3000: gnt at +1, rvalid at +3, idle at +4
  task automatic test_fetch_read();
    f_addr = 16'h3000; f_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({f_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 16'h3000) begin
      tests_failed++;
      $display("FAIL fetch_issue: gnt/en/we=%b addr=%h want 110 3000", {f_gnt, mem_en, mem_we}, mem_addr);
    end
    f_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_en, busy, f_rvalid, f_gnt} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL fetch_wait: en/busy/rvalid/gnt=%b want 0100", {mem_en, busy, f_rvalid, f_gnt});
    end
    @(negedge clk);
    tests_run++;
    if (f_rvalid !== 1'b1 || rdata !== 16'h1234) begin
      tests_failed++;
      $display("FAIL fetch_resp: rvalid=%b rdata=%h want 1 1234", f_rvalid, rdata);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || f_rvalid !== 1'b0 || rdata !== 16'h1234) begin
      tests_failed++;
      $display("FAIL fetch_idle: busy=%b rvalid=%b rdata=%h want 0 0 1234", busy, f_rvalid, rdata);
    end
  endtask

  task automatic test_dbg_write();
    int unsigned rv_seen = 0;
    dbg_addr = 16'h0010; dbg_wdata = 16'hBEEF; dbg_we = 1'b1; dbg_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({dbg_gnt, d_gnt, f_gnt, mem_en, mem_we} !== 5'b10011 ||
        mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL dbg_write_issue: gnt/en/we=%b addr=%h wdata=%h want 10011 0010 beef",
               {dbg_gnt, d_gnt, f_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_en, mem_we, busy, dbg_gnt} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL dbg_write_done: en/we/busy/gnt=%b want 0000", {mem_en, mem_we, busy, dbg_gnt});
    end
    for (int i = 0; i < 4; i++) begin
      if (f_rvalid || d_rvalid || dbg_rvalid) rv_seen++;
      @(negedge clk);
    end
    tests_run++;
    if (rv_seen !== 0) begin
      tests_failed++;
      $display("FAIL dbg_write_no_rvalid: rvalid cycles=%0d want 0", rv_seen);
    end
  endtask

  // All three raised together: expect dbg, data, fetch, each with own data
  task automatic test_priority();
    int unsigned ngnt = 0, nrv = 0, multi = 0;
    logic [2:0] order [3];
    logic [2:0] want [3];
    want[0] = 3'b100; want[1] = 3'b010; want[2] = 3'b001;
    for (int i = 0; i < 3; i++) order[i] = '0;
    f_addr = 16'h3000; d_addr = 16'h0200; d_we = 1'b0; dbg_addr = 16'h0400; dbg_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1; dbg_req = 1'b1;
    for (int cyc = 0; cyc < 40 && nrv < 3; cyc++) begin
      @(negedge clk);
      if ($countones({f_gnt, d_gnt, dbg_gnt}) > 1 ||
          $countones({f_rvalid, d_rvalid, dbg_rvalid}) > 1) multi++;
      if (dbg_gnt || d_gnt || f_gnt) begin
        if (ngnt < 3) order[ngnt] = {dbg_gnt, d_gnt, f_gnt};
        ngnt++;
      end
      if (dbg_gnt) dbg_req = 1'b0;
      if (d_gnt)   d_req = 1'b0;
      if (f_gnt)   f_req = 1'b0;
      if (dbg_rvalid) begin
        nrv++; tests_run++;
        if (rdata !== 16'h0F0F) begin
          tests_failed++; $display("FAIL prio_dbg_rdata: got %h want 0f0f", rdata);
        end
      end
      if (d_rvalid) begin
        nrv++; tests_run++;
        if (rdata !== 16'h5A5A) begin
          tests_failed++; $display("FAIL prio_d_rdata: got %h want 5a5a", rdata);
        end
      end
      if (f_rvalid) begin
        nrv++; tests_run++;
        if (rdata !== 16'h1234) begin
          tests_failed++; $display("FAIL prio_f_rdata: got %h want 1234", rdata);
        end
      end
    end
    tests_run++;
    if (ngnt !== 3 || nrv !== 3 || multi !== 0) begin
      tests_failed++;
      $display("FAIL prio_counts: gnts=%0d rvalids=%0d overlaps=%0d want 3 3 0", ngnt, nrv, multi);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (order[i] !== want[i]) begin
        tests_failed++;
        $display("FAIL prio_order[%0d]: got %b want %b", i, order[i], want[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // f_req and d_req held high: D D D D F repeating
  task automatic test_starve();
    int unsigned ngnt = 0;
    logic [1:0] seq [10];
    for (int i = 0; i < 10; i++) seq[i] = '0;
    f_addr = 16'h3000; d_addr = 16'h0200; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    for (int cyc = 0; cyc < 100 && ngnt < 10; cyc++) begin
      @(negedge clk);
      if (d_gnt || f_gnt) begin
        seq[ngnt] = {d_gnt, f_gnt};
        ngnt++;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    tests_run++;
    if (ngnt !== 10) begin
      tests_failed++;
      $display("FAIL starve_budget: grants=%0d want 10", ngnt);
    end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (seq[i] !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin
        tests_failed++;
        $display("FAIL starve_seq[%0d]: got d/f=%b want %b", i, seq[i],
                 (i % 5 == 4) ? 2'b01 : 2'b10);
      end
    end
    for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_drain: busy=%b want 0", busy);
    end
    @(negedge clk);
  endtask

  // RD_LAT=3: mem_rdata3 = 0x1000+k in cycle N+k; capture from cycle N+4
  task automatic test_rdlat3();
    d_addr3 = 16'h0200; d_we3 = 1'b0; d_req3 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      mem_rdata3 = 16'h1000 + 16'(k);
      if (k == 1) begin
        tests_run++;
        if ({d_gnt3, mem_en3, mem_we3} !== 3'b110 || mem_addr3 !== 16'h0200) begin
          tests_failed++;
          $display("FAIL lat3_issue: gnt/en/we=%b addr=%h want 110 0200", {d_gnt3, mem_en3, mem_we3}, mem_addr3);
        end
        d_req3 = 1'b0;
      end else if (k <= 4) begin
        tests_run++;
        if ({busy3, mem_en3, d_rvalid3} !== 3'b100) begin
          tests_failed++;
          $display("FAIL lat3_wait%0d: busy/en/rvalid=%b want 100", k, {busy3, mem_en3, d_rvalid3});
        end
      end else if (k == 5) begin
        tests_run++;
        if (d_rvalid3 !== 1'b1 || rdata3 !== 16'h1004) begin
          tests_failed++;
          $display("FAIL lat3_resp: rvalid=%b rdata=%h want 1 1004", d_rvalid3, rdata3);
        end
      end else begin
        tests_run++;
        if (busy3 !== 1'b0 || d_rvalid3 !== 1'b0) begin
          tests_failed++;
          $display("FAIL lat3_idle: busy=%b rvalid=%b want 0 0", busy3, d_rvalid3);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int unsigned rv_seen = 0;
    f_addr = 16'h3000; f_req = 1'b1;
    @(negedge clk);
    f_req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({f_gnt, f_rvalid, mem_en, mem_we, busy} !== 5'b0 || mem_addr !== 16'h0 || rdata !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_wait_async: ctrl=%b addr=%h rdata=%h want 0",
               {f_gnt, f_rvalid, mem_en, mem_we, busy}, mem_addr, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (f_rvalid || busy) rv_seen++;
    end
    tests_run++;
    if (rv_seen !== 0) begin
      tests_failed++;
      $display("FAIL rst_wait_no_rvalid: active cycles=%0d want 0", rv_seen);
    end
    f_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if (f_gnt !== 1'b1 || mem_addr !== 16'h3000) begin
      tests_failed++;
      $display("FAIL rst_wait_regrant: gnt=%b addr=%h want 1 3000", f_gnt, mem_addr);
    end
    f_req = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (f_rvalid !== 1'b1 || rdata !== 16'h1234) begin
      tests_failed++;
      $display("FAIL rst_wait_reread: rvalid=%b rdata=%h want 1 1234", f_rvalid, rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_dbg_write();
    test_priority();
    test_starve();
    test_rdlat3();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
